// File: rtl/reboot_ctrl_if.sv
// rtl/reboot_ctrl_if.sv - zero-wait-state register bus between a host and reboot_ctrl
interface reboot_ctrl_if;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/reboot_ctrl.sv
// rtl/reboot_ctrl.sv - key-unlocked multiboot reboot sequencer driving the ICAP unit
// Optional watchdog (registers 4/5, STATUS[4]) compiled in with REBOOT_CTRL_WDT_EN.
module reboot_ctrl #(
  parameter logic [24:0] GOLDEN_ADDR = 25'h000000,
  parameter int unsigned PULSE_LEN   = 8
) (
  input  logic         mem_clk,
  input  logic         rst_n,
  reboot_ctrl_if.slave bus,
  input  logic         reboot_key,
  output logic [24:0]  spi_addr,
  output logic         reboot,
  output logic         busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNLOCK = 3'd1,
    ST_COUNT  = 3'd2,
    ST_FIRE   = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  localparam logic [3:0]  REG_ADDR     = 4'd0;
  localparam logic [3:0]  REG_KEY      = 4'd1;
  localparam logic [3:0]  REG_DELAY    = 4'd2;
  localparam logic [3:0]  REG_STATUS   = 4'd3;
  localparam logic [3:0]  REG_WDT_LOAD = 4'd4;
  localparam logic [3:0]  REG_WDT_KICK = 4'd5;
  localparam logic [31:0] KEY_UNLOCK   = 32'h5A5A_0001;
  localparam logic [31:0] KEY_ARM      = 32'hA5A5_0002;
  localparam logic [31:0] KEY_ABORT    = 32'h0000_0000;
  localparam logic [31:0] WDT_KICK_VAL = 32'hC0DE_CAFE;
  localparam logic [7:0]  PULSE_RELOAD = 8'(PULSE_LEN - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pulse_q, pulse_d;
  logic [24:0] addr_q;
  logic [15:0] delay_q;
  logic        key_meta_q, key_sync_q, key_prev_q;
  logic        reboot_q, busy_q;
  logic        load_golden;
  logic        wr, key_wr, key_rise;
  logic        wdt_expire, wdt_fired;
  logic [31:0] wdt_load_rd;
  logic [31:0] rdata;

  assign wr       = bus.mem_valid && (bus.mem_wstrb == 4'hF);
  assign key_wr   = wr && (bus.mem_addr == REG_KEY);
  assign key_rise = key_sync_q && !key_prev_q;

  // Priority: watchdog expiry, then push-button edge, then bus KEY writes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_d     = pulse_q;
    load_golden = 1'b0;
    if (wdt_expire && (state_q != ST_FIRE) && (state_q != ST_LOCKED)) begin
      state_d     = ST_FIRE;
      pulse_d     = PULSE_RELOAD;
      load_golden = 1'b1;
    end else if (key_rise && ((state_q == ST_IDLE) || (state_q == ST_UNLOCK))) begin
      state_d     = ST_COUNT;
      cnt_d       = delay_q;
      load_golden = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_wr && (bus.mem_wdata == KEY_UNLOCK)) state_d = ST_UNLOCK;
        end
        ST_UNLOCK: begin
          if (key_wr) begin
            if (bus.mem_wdata == KEY_ARM) begin
              state_d = ST_COUNT;
              cnt_d   = delay_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_COUNT: begin
          if (key_wr && (bus.mem_wdata == KEY_ABORT)) begin
            state_d = ST_IDLE;
          end else if (cnt_q == 16'd0) begin
            state_d = ST_FIRE;
            pulse_d = PULSE_RELOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_FIRE: begin
          if (pulse_q == 8'd0) state_d = ST_LOCKED;
          else                 pulse_d = pulse_q - 8'd1;
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pulse_q    <= '0;
      addr_q     <= '0;
      delay_q    <= '0;
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_prev_q <= 1'b0;
      reboot_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      key_meta_q <= reboot_key;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      reboot_q   <= (state_d == ST_FIRE);
      busy_q     <= (state_d != ST_IDLE);
      if (load_golden)
        addr_q <= GOLDEN_ADDR;
      else if (wr && (bus.mem_addr == REG_ADDR) && (state_q == ST_IDLE))
        addr_q <= bus.mem_wdata[24:0];
      if (wr && (bus.mem_addr == REG_DELAY) && (state_q == ST_IDLE))
        delay_q <= bus.mem_wdata[15:0];
    end
  end

`ifdef REBOOT_CTRL_WDT_EN
  logic [31:0] wdt_load_q, wdt_cnt_q;
  logic        wdt_run_q, wdt_fired_q;

  assign wdt_expire  = wdt_run_q && (wdt_cnt_q == 32'd0);
  assign wdt_fired   = wdt_fired_q;
  assign wdt_load_rd = wdt_load_q;

  // The counter stops after expiring so a single timeout produces a single reboot.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_load_q  <= '0;
      wdt_cnt_q   <= '0;
      wdt_run_q   <= 1'b0;
      wdt_fired_q <= 1'b0;
    end else begin
      if (wdt_expire) begin
        wdt_run_q <= 1'b0;
      end else if (wr && (bus.mem_addr == REG_WDT_LOAD)) begin
        wdt_load_q <= bus.mem_wdata;
        wdt_cnt_q  <= bus.mem_wdata;
        wdt_run_q  <= (bus.mem_wdata != 32'd0);
      end else if (wr && (bus.mem_addr == REG_WDT_KICK) && (bus.mem_wdata == WDT_KICK_VAL)) begin
        wdt_cnt_q <= wdt_load_q;
      end else if (wdt_run_q) begin
        wdt_cnt_q <= wdt_cnt_q - 32'd1;
      end
      if (wdt_expire && (state_q != ST_FIRE) && (state_q != ST_LOCKED))
        wdt_fired_q <= 1'b1;
    end
  end
`else
  assign wdt_expire  = 1'b0;
  assign wdt_fired   = 1'b0;
  assign wdt_load_rd = 32'd0;
`endif

  always_comb begin
    rdata = 32'd0;
    if (bus.mem_valid) begin
      case (bus.mem_addr)
        REG_ADDR:     rdata = {7'd0, addr_q};
        REG_DELAY:    rdata = {16'd0, delay_q};
        REG_STATUS:   rdata = {27'd0, wdt_fired, key_sync_q, state_q};
        REG_WDT_LOAD: rdata = wdt_load_rd;
        default:      rdata = 32'd0;
      endcase
    end
  end

  assign bus.mem_ready = bus.mem_valid;
  assign bus.mem_rdata = rdata;
  assign spi_addr      = addr_q;
  assign reboot        = reboot_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_reboot_ctrl.sv
// tb/tb_reboot_ctrl.sv - scoreboard bench for reboot_ctrl (reads and reboot pulses)
module tb_reboot_ctrl;
  localparam logic [24:0] GOLDEN = 25'h0123456;
  localparam int          PLEN   = 8;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    int          rise;
    logic [24:0] addr;
    int          len;
  } rb_exp_t;

  logic        mem_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        reboot_key = 1'b0;
  logic [24:0] spi_addr;
  logic        reboot;
  logic        busy;

  reboot_ctrl_if bus();

  reboot_ctrl #(.GOLDEN_ADDR(GOLDEN), .PULSE_LEN(PLEN)) dut (
    .mem_clk    (mem_clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .reboot_key (reboot_key),
    .spi_addr   (spi_addr),
    .reboot     (reboot),
    .busy       (busy)
  );

  always #5 mem_clk = ~mem_clk;

  int cyc = 0;
  always @(posedge mem_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_acc = 0;
  rd_exp_t rd_q[$];
  rb_exp_t rb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_s(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge mem_clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    @(posedge mem_clk); #1;
    last_acc      = cyc;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_s(a, d, 4'hF);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.addr = a;
    e.data = exp;
    rd_q.push_back(e);
    @(posedge mem_clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wstrb = 4'h0;
    @(posedge mem_clk); #1;
    bus.mem_valid = 1'b0;
  endtask

  task automatic expect_reboot(input int rise, input logic [24:0] a, input int len);
    rb_exp_t e;
    e.rise = rise;
    e.addr = a;
    e.len  = len;
    rb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge mem_clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge mem_clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops expected read data on every read beat and tracks reboot pulses.
  logic reb_prev = 1'b0;
  int   hi_len   = 0;
  int   len_exp  = 0;
  always @(negedge mem_clk) begin
    if (bus.mem_valid && bus.mem_wstrb == 4'h0) begin
      chk("mem_ready", {31'd0, bus.mem_ready}, 32'd1);
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got read of reg %0d, expected none", bus.mem_addr);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk($sformatf("rdata_reg%0d", e.addr), bus.mem_rdata, e.data);
      end
    end
    if (reboot && !reb_prev) begin
      if (rb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL reboot_unexpected: got rise at cycle %0d, expected none", cyc);
      end else begin
        rb_exp_t r;
        r = rb_q.pop_front();
        chk("reboot_rise_cycle", cyc, r.rise);
        chk("spi_addr_at_fire", {7'd0, spi_addr}, {7'd0, r.addr});
        len_exp = r.len;
      end
      hi_len = 1;
    end else if (reboot) begin
      hi_len++;
    end else if (reb_prev) begin
      chk("reboot_len", hi_len, len_exp);
    end
    reb_prev = reboot;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 4'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_wstrb = 4'h0;
    repeat (3) @(posedge mem_clk);
    #1;
    chk("rst_reboot", {31'd0, reboot}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_spi_addr", {7'd0, spi_addr}, 32'd0);
    chk("idle_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("idle_rdata", bus.mem_rdata, 32'd0);
    rst_n = 1'b1;
    rd(4'd3, 32'd0);
    rd(4'd0, 32'd0);
    rd(4'd2, 32'd0);

    // Normal two-key sequence with DELAY=3, then LOCKED ignores everything.
    wr(4'd0, 32'h0008_0000);
    wr(4'd2, 32'd3);
    rd(4'd0, 32'h0008_0000);
    rd(4'd2, 32'd3);
    wr(4'd1, 32'h5A5A_0001);
    rd(4'd3, 32'd1);
    rd(4'd1, 32'd0);
    wr(4'd1, 32'hA5A5_0002);
    expect_reboot(last_acc + 4, 25'h0080000, PLEN);
    repeat (20) @(posedge mem_clk);
    #1 chk("locked_busy", {31'd0, busy}, 32'd1);
    rd(4'd3, 32'd4);
    wr(4'd1, 32'h5A5A_0001);
    wr(4'd0, 32'h0000_1234);
    rd(4'd3, 32'd4);
    rd(4'd0, 32'h0008_0000);

    // Wrong second key and partial-strobe key write both leave IDLE.
    do_reset();
    wr(4'd1, 32'h5A5A_0001);
    wr(4'd1, 32'h1234_5678);
    rd(4'd3, 32'd0);
    wr_s(4'd1, 32'h5A5A_0001, 4'h7);
    rd(4'd3, 32'd0);

    // Abort during a long countdown; DELAY is frozen while armed.
    wr(4'd2, 32'd100);
    wr(4'd1, 32'h5A5A_0001);
    wr(4'd1, 32'hA5A5_0002);
    repeat (10) @(posedge mem_clk);
    #1 chk("count_busy", {31'd0, busy}, 32'd1);
    rd(4'd3, 32'd2);
    wr(4'd2, 32'd5);
    rd(4'd2, 32'd100);
    wr(4'd1, 32'h0000_0000);
    rd(4'd3, 32'd0);
    repeat (110) @(posedge mem_clk);
    rd(4'd3, 32'd0);

    // DELAY=0 fires on the cycle right after the arming write.
    do_reset();
    wr(4'd2, 32'd0);
    wr(4'd1, 32'h5A5A_0001);
    wr(4'd1, 32'hA5A5_0002);
    expect_reboot(last_acc + 1, 25'h0000000, PLEN);
    repeat (12) @(posedge mem_clk);
    rd(4'd3, 32'd4);

    // Push-button in IDLE: 3 sync/edge cycles, then DELAY+1.
    do_reset();
    wr(4'd0, 32'h0008_0000);
    wr(4'd2, 32'd3);
    #1 chk("pre_key_spi_addr", {7'd0, spi_addr}, 32'h0008_0000);
    @(posedge mem_clk); #1;
    c0 = cyc;
    reboot_key = 1'b1;
    expect_reboot(c0 + 7, GOLDEN, PLEN);
    repeat (3) @(posedge mem_clk);
    #1 reboot_key = 1'b0;
    repeat (16) @(posedge mem_clk);
    rd(4'd0, {7'd0, GOLDEN});
    rd(4'd3, 32'd4);

    // Watchdog registers, or their absence.
    do_reset();
    rd(4'd9, 32'd0);
    wr(4'd7, 32'hFFFF_FFFF);
    rd(4'd7, 32'd0);
`ifdef REBOOT_CTRL_WDT_EN
    wr(4'd4, 32'd50);
    for (int k = 0; k < 4; k++) begin
      repeat (38) @(posedge mem_clk);
      wr(4'd5, 32'hC0DE_CAFE);
    end
    rd(4'd4, 32'd50);
    wr(4'd4, 32'd0);
    repeat (60) @(posedge mem_clk);
    rd(4'd3, 32'd0);
    wr(4'd4, 32'd50);
    expect_reboot(last_acc + 51, GOLDEN, PLEN);
    repeat (65) @(posedge mem_clk);
    rd(4'd3, 32'h14);
`else
    wr(4'd4, 32'd50);
    rd(4'd4, 32'd0);
    wr(4'd5, 32'hC0DE_CAFE);
    rd(4'd5, 32'd0);
    repeat (60) @(posedge mem_clk);
    rd(4'd3, 32'd0);
`endif

    // Reset in the middle of the pulse drops reboot without waiting for a clock.
    do_reset();
    wr(4'd0, 32'h0000_1234);
    wr(4'd2, 32'd2);
    wr(4'd1, 32'h5A5A_0001);
    wr(4'd1, 32'hA5A5_0002);
    expect_reboot(last_acc + 3, 25'h0001234, 2);
    repeat (5) @(posedge mem_clk);
    #1 chk("fire_reboot", {31'd0, reboot}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_reboot", {31'd0, reboot}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_spi_addr", {7'd0, spi_addr}, 32'd0);
    repeat (2) @(posedge mem_clk);
    #1 rst_n = 1'b1;
    rd(4'd0, 32'd0);
    rd(4'd2, 32'd0);
    rd(4'd3, 32'd0);
    rd(4'd4, 32'd0);
    repeat (5) @(posedge mem_clk);

    chk("rd_q_drained", rd_q.size(), 32'd0);
    chk("rb_q_drained", rb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reboot_ctrl.md
REBOOT_CTRL -- requirements
Module: reboot_ctrl

Interface
REQ-001 SHALL have parameter GOLDEN_ADDR, default 25'h000000: fallback bitstream SPI address.
REQ-002 SHALL have parameter PULSE_LEN, default 8: cycles reboot is held high (legal range 1..255).
REQ-003 SHALL have port mem_clk, input, 1: sole clock.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mem_valid, input, 1: bus access request.
REQ-006 SHALL have port mem_addr, input, 4: word register index.
REQ-007 SHALL have port mem_wdata, input, 32: write data.
REQ-008 SHALL have port mem_wstrb, input, 4: byte strobes; a write requires all four high.
REQ-009 SHALL have port reboot_key, input, 1: asynchronous push-button, active-high.
REQ-010 SHALL have port mem_ready, output, 1: access acknowledge.
REQ-011 SHALL have port mem_rdata, output, 32: read data.
REQ-012 SHALL have port spi_addr, output, 25: target address to the ICAP multiboot unit.
REQ-013 SHALL have port reboot, output, 1: reboot command to the ICAP multiboot unit.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 SHALL drive mem_ready = mem_valid combinationally (zero wait states); mem_rdata SHALL be 0 when mem_valid is low.
REQ-016 SHALL implement registers: 0 ADDR (rw, 25 bits, zero-extended); 1 KEY (wo, reads 0); 2 DELAY (rw, 16 bits); 3 STATUS (ro: [2:0] state, [3] synchronized reboot_key, [4] wdt_fired); 4 WDT_LOAD (rw, 32 bits); 5 WDT_KICK (wo, reads 0); other indices read 0 and ignore writes.
REQ-017 SHALL ignore writes to ADDR and DELAY when state is not IDLE.
REQ-018 SHALL implement states IDLE=0, UNLOCK=1, COUNT=2, FIRE=3, LOCKED=4.
REQ-019 IDLE->UNLOCK on KEY write of 32'h5A5A_0001; any other KEY write SHALL leave IDLE.
REQ-020 UNLOCK->COUNT on KEY write of 32'hA5A5_0002; any other KEY write SHALL return to IDLE; non-KEY accesses SHALL not affect UNLOCK.
REQ-021 On entry to COUNT the 16-bit counter SHALL load DELAY; it decrements each cycle; the cycle it reads 0 the state SHALL advance to FIRE, so reboot rises exactly DELAY+1 cycles after the accepting edge (DELAY=0 gives 1).
REQ-022 In COUNT a KEY write of 32'h0000_0000 SHALL abort to IDLE with reboot never asserted.
REQ-023 In FIRE reboot SHALL be high for exactly PULSE_LEN cycles, then state SHALL go to LOCKED with reboot low.
REQ-024 LOCKED SHALL be terminal until reset; all KEY writes ignored.
REQ-025 reboot_key SHALL pass a 2-flop synchronizer; a synchronized rising edge in IDLE or UNLOCK SHALL load ADDR with GOLDEN_ADDR and enter COUNT; in other states it SHALL be ignored.
REQ-026 spi_addr SHALL equal the ADDR register at all times; reboot SHALL be high only in FIRE.
REQ-027 Simultaneous events priority: watchdog expiry > reboot_key edge > bus KEY write.

Reset
REQ-028 On rst_n low: ADDR=0, DELAY=0, WDT_LOAD=0, counters=0, wdt_fired=0, state=IDLE, reboot=0, busy=0, synchronizer flops=0; reset mid-FIRE SHALL deassert reboot immediately.

Configuration
REQ-029 Macro REBOOT_CTRL_WDT_EN SHALL compile in the watchdog; without it registers 4 and 5 read 0, ignore writes, and wdt_fired stays 0.
REQ-030 With REBOOT_CTRL_WDT_EN: writing WDT_LOAD nonzero loads and starts a 32-bit down-counter, writing 0 stops it; WDT_KICK write of 32'hC0DE_CAFE reloads WDT_LOAD; on reaching 0 in any state except FIRE/LOCKED it SHALL set wdt_fired, load ADDR with GOLDEN_ADDR, and enter FIRE next cycle.

Verification
REQ-031 ADDR=0x80000, DELAY=3, KEY 0x5A5A0001 then 0xA5A50002 -> reboot high 4 cycles after second write, for 8 cycles, spi_addr=0x80000, then STATUS reads 4.
REQ-032 KEY 0x5A5A0001 then 0x12345678 -> STATUS returns 0, reboot stays 0.
REQ-033 Armed with DELAY=100, KEY 0x0 after 10 cycles -> IDLE, reboot never asserted.
REQ-034 Pulse reboot_key in IDLE with ADDR=0x80000 -> spi_addr becomes GOLDEN_ADDR, reboot fires after DELAY+1 cycles.
REQ-035 WDT_EN: WDT_LOAD=50, no kick -> STATUS[4]=1, reboot high ~51 cycles after load; kicking every 40 cycles -> never fires.
REQ-036 Assert rst_n low during FIRE -> reboot 0 asynchronously, all registers at reset values.
